alu_result_serializer: RTL and testbench

ALU_RESULT_SERIALIZER -- requirements
Module: alu_result_serializer

---
 rtl/alu_result_serializer.sv | 115 +++++++++++
 tb/tb_alu_result_serializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_serializer.sv
// Captures a result word from the ALU on OUT_VALID and shifts it out on TX_OUT as a
// frame: start bit 0, WIDTH data bits LSB first, optional parity bit, stop bit 1.
module alu_result_serializer #(
    parameter int WIDTH   = 16,
    parameter int PAR_EN  = 1,
    parameter int PAR_TYP = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] ALU_OUT,
    input  logic             OUT_VALID,
    output logic             TX_OUT,
    output logic             BUSY,
    output logic             DROP
);
    // state  | meaning
    // IDLE   | line idle at 1, waiting for OUT_VALID
    // START  | start bit 0 on the line
    // DATA   | WIDTH data bits, LSB first
    // PARITY | parity bit (only reachable when PAR_EN=1)
    // STOP   | stop bit 1; a word offered on exit starts the next frame directly
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic          PAR_INV  = (PAR_TYP != 0);

    state_t           r_state, w_state;
    logic [WIDTH-1:0] r_shift, w_shift;
    logic [CW-1:0]    r_cnt, w_cnt;
    logic             r_par, w_par;
    logic             r_tx, w_tx;
    logic             r_busy, w_busy;
    logic             r_drop, w_drop;
    logic             w_capture;

    // Outputs are registered, so each branch computes the line level of the next cycle.
    always_comb begin
        w_state   = r_state;
        w_shift   = r_shift;
        w_cnt     = r_cnt;
        w_par     = r_par;
        w_tx      = 1'b1;
        w_drop    = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                w_capture = OUT_VALID;
            end
            START: begin
                w_state = DATA;
                w_tx    = r_shift[0];
                w_shift = r_shift >> 1;
                w_cnt   = '0;
                w_drop  = OUT_VALID;
            end
            DATA: begin
                w_drop = OUT_VALID;
                if (r_cnt == LAST_BIT) begin
                    if (PAR_EN != 0) begin
                        w_state = PARITY;
                        w_tx    = r_par;
                    end else begin
                        w_state = STOP;
                    end
                end else begin
                    w_tx    = r_shift[0];
                    w_shift = r_shift >> 1;
                    w_cnt   = r_cnt + 1'b1;
                end
            end
            PARITY: begin
                w_state = STOP;
                w_drop  = OUT_VALID;
            end
            STOP: begin
                if (OUT_VALID) w_capture = 1'b1;
                else           w_state   = IDLE;
            end
            default: w_state = IDLE;
        endcase
        if (w_capture) begin
            w_state = START;
            w_shift = ALU_OUT;
            w_par   = (^ALU_OUT) ^ PAR_INV;
            w_cnt   = '0;
            w_tx    = 1'b0;
        end
        w_busy = (w_state != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_shift <= w_shift;
            r_cnt   <= w_cnt;
            r_par   <= w_par;
            r_tx    <= w_tx;
            r_busy  <= w_busy;
            r_drop  <= w_drop;
        end
    end

    assign TX_OUT = r_tx;
    assign BUSY   = r_busy;
    assign DROP   = r_drop;
endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer: even-parity, odd-parity and no-parity
// instances share the same stimulus; each scenario checks one of them cycle by cycle.
module tb_alu_result_serializer;
    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] ALU_OUT;
    logic        OUT_VALID;
    logic        tx_e, busy_e, drop_e;
    logic        tx_o, busy_o, drop_o;
    logic        tx_n, busy_n, drop_n;

    int n_cmp = 0;
    int n_err = 0;

    alu_result_serializer #(.WIDTH(16), .PAR_EN(1), .PAR_TYP(0)) dut_even (
        .CLK(CLK), .RST(RST), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
        .TX_OUT(tx_e), .BUSY(busy_e), .DROP(drop_e));
    alu_result_serializer #(.WIDTH(16), .PAR_EN(1), .PAR_TYP(1)) dut_odd (
        .CLK(CLK), .RST(RST), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
        .TX_OUT(tx_o), .BUSY(busy_o), .DROP(drop_o));
    alu_result_serializer #(.WIDTH(16), .PAR_EN(0), .PAR_TYP(0)) dut_nopar (
        .CLK(CLK), .RST(RST), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
        .TX_OUT(tx_n), .BUSY(busy_n), .DROP(drop_n));

    always #5 CLK = ~CLK;

    // {TX_OUT, BUSY, DROP} of the selected instance: 0 even, 1 odd, 2 no parity
    function automatic logic [2:0] obs(input int sel);
        case (sel)
            0:       return {tx_e, busy_e, drop_e};
            1:       return {tx_o, busy_o, drop_o};
            default: return {tx_n, busy_n, drop_n};
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic capture(input logic [15:0] w);
        ALU_OUT   = w;
        OUT_VALID = 1'b1;
        tick();
        OUT_VALID = 1'b0;
    endtask

    task automatic drain();
        OUT_VALID = 1'b0;
        repeat (25) tick();
    endtask

    task automatic check_idle(input string nm, input int sel);
        n_cmp++;
        if (obs(sel) !== 3'b100) begin
            n_err++;
            $display("FAIL %s idle: {tx,busy,drop}=%b required 100", nm, obs(sel));
        end
    endtask

    // Called in the START cycle; returns in the cycle after the stop bit.
    task automatic expect_frame(input string nm, input int sel, input logic [15:0] w,
                                input logic par_en, input logic par, input int inj_at,
                                input logic chain, input logic [15:0] nxt,
                                input logic scramble, input logic hold);
        int len = par_en ? 19 : 18;
        logic       e_tx, e_drop;
        logic [2:0] o;
        for (int c = 0; c < len; c++) begin
            if (c == 0)                    e_tx = 1'b0;
            else if (c <= 16)              e_tx = w[c-1];
            else if (par_en && c == 17)    e_tx = par;
            else                           e_tx = 1'b1;
            e_drop = hold ? (c != 0) : (inj_at >= 0 && c == inj_at + 1);
            o = obs(sel);
            n_cmp++;
            if (o !== {e_tx, 1'b1, e_drop}) begin
                n_err++;
                $display("FAIL %s cycle %0d: {tx,busy,drop}=%b required %b",
                         nm, c, o, {e_tx, 1'b1, e_drop});
            end
            OUT_VALID = hold;
            if (scramble) ALU_OUT = 16'($urandom);
            if (c == inj_at) begin
                OUT_VALID = 1'b1;
                ALU_OUT   = 16'h1234;
            end
            if (c == len - 1) begin
                OUT_VALID = chain;
                if (chain) ALU_OUT = nxt;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            n_cmp++;
            if (obs(s) !== 3'b100) begin
                n_err++;
                $display("FAIL reset dut%0d: {tx,busy,drop}=%b required 100", s, obs(s));
            end
        end
    endtask

    task automatic test_even_0001();
        capture(16'h0001);
        expect_frame("even_0001", 0, 16'h0001, 1'b1, 1'b1, -1, 1'b0, 16'h0, 1'b0, 1'b0);
        check_idle("even_0001", 0);
        drain();
    endtask

    task automatic test_odd_and_nopar();
        capture(16'hFFFF);
        expect_frame("odd_ffff", 1, 16'hFFFF, 1'b1, 1'b1, -1, 1'b0, 16'h0, 1'b0, 1'b0);
        check_idle("odd_ffff", 1);
        drain();
        capture(16'hFFFF);
        expect_frame("nopar_ffff", 2, 16'hFFFF, 1'b0, 1'b0, -1, 1'b0, 16'h0, 1'b0, 1'b0);
        check_idle("nopar_ffff", 2);
        drain();
    endtask

    task automatic test_drop();
        capture(16'hA5A5);
        expect_frame("drop_a5a5", 0, 16'hA5A5, 1'b1, 1'b0, 4, 1'b0, 16'h0, 1'b0, 1'b0);
        check_idle("drop_after", 0);
        repeat (3) tick();
        check_idle("drop_no_1234", 0);
        drain();
    endtask

    task automatic test_back_to_back();
        capture(16'h8000);
        expect_frame("b2b_8000", 0, 16'h8000, 1'b1, 1'b1, -1, 1'b1, 16'h00FF, 1'b0, 1'b0);
        expect_frame("b2b_00ff", 0, 16'h00FF, 1'b1, 1'b0, -1, 1'b0, 16'h0, 1'b0, 1'b0);
        check_idle("b2b_end", 0);
        drain();
    endtask

    task automatic test_hold_valid();
        capture(16'h0003);
        expect_frame("hold_f1", 0, 16'h0003, 1'b1, 1'b0, -1, 1'b1, 16'h0003, 1'b0, 1'b1);
        expect_frame("hold_f2", 0, 16'h0003, 1'b1, 1'b0, -1, 1'b0, 16'h0, 1'b0, 1'b1);
        check_idle("hold_end", 0);
        drain();
    endtask

    task automatic test_scramble();
        capture(16'h5555);
        expect_frame("scramble_5555", 0, 16'h5555, 1'b1, 1'b0, -1, 1'b0, 16'h0, 1'b1, 1'b0);
        check_idle("scramble_end", 0);
        drain();
    endtask

    task automatic test_reset_midframe();
        capture(16'hFFFF);
        repeat (8) tick();
        n_cmp++;
        if (obs(0) !== 3'b110) begin
            n_err++;
            $display("FAIL rst_mid bit7: {tx,busy,drop}=%b required 110", obs(0));
        end
        #2 RST = 1'b0;
        #1;
        n_cmp++;
        if (obs(0) !== 3'b100) begin
            n_err++;
            $display("FAIL rst_mid async: {tx,busy,drop}=%b required 100", obs(0));
        end
        @(posedge CLK);
        #3 RST = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            n_cmp++;
            if (obs(0) !== 3'b100) begin
                n_err++;
                $display("FAIL rst_mid quiet cycle %0d: {tx,busy,drop}=%b required 100",
                         c, obs(0));
            end
        end
    endtask

    initial begin
        RST       = 1'b0;
        OUT_VALID = 1'b0;
        ALU_OUT   = 16'h0;
        tick();
        tick();
        test_reset();
        RST = 1'b1;
        tick();
        test_even_0001();
        test_odd_and_nopar();
        test_drop();
        test_back_to_back();
        test_hold_valid();
        test_scramble();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
